// File: rtl/pll_pkg.sv
// Shared types and constants for the fractional-N clock synthesiser.
package pll_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } pll_state_e;

    // Active configuration after reset: divide by 2, no fractional part.
    localparam int RST_INT  = 2;
    localparam int RST_FRAC = 0;
    localparam int RST_DEN  = 1;

    // Smallest integer ratio that still gives one high and one low cycle.
    localparam int MIN_INT  = 2;

endpackage

// File: rtl/pll_frac_acc.sv
// First-order fractional accumulator. Holds acc and the active frac/den,
// and produces the carry that stretches a period from N to N+1.
// A load on the same edge as a step makes the step use the new frac/den
// with acc starting from zero.
module pll_frac_acc
    import pll_pkg::*;
#(
    parameter int FRAC_W = 12
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              i_step,
    input  logic              i_load,
    input  logic [FRAC_W-1:0] i_frac,
    input  logic [FRAC_W-1:0] i_den,
    output logic              o_carry
);

    logic [FRAC_W-1:0] r_acc;
    logic [FRAC_W-1:0] r_frac;
    logic [FRAC_W-1:0] r_den;

    logic [FRAC_W-1:0] w_acc_base;
    logic [FRAC_W-1:0] w_frac;
    logic [FRAC_W-1:0] w_den;
    logic [FRAC_W:0]   w_sum;
    logic [FRAC_W-1:0] w_diff;

    assign w_acc_base = i_load ? '0 : r_acc;
    assign w_frac     = i_load ? i_frac : r_frac;
    assign w_den      = i_load ? i_den : r_den;
    assign w_sum      = {1'b0, w_acc_base} + {1'b0, w_frac};
    assign o_carry    = (w_sum >= {1'b0, w_den});
    // When carry is set the difference is below den, so it fits FRAC_W bits.
    assign w_diff     = w_sum[FRAC_W-1:0] - w_den;

    // Accumulator update on each period start; config load restarts the phase.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_acc  <= '0;
            r_frac <= FRAC_W'(RST_FRAC);
            r_den  <= FRAC_W'(RST_DEN);
        end else begin
            if (i_load) begin
                r_frac <= i_frac;
                r_den  <= i_den;
            end
            if (i_step) begin
                r_acc <= o_carry ? w_diff : w_sum[FRAC_W-1:0];
            end else if (i_load) begin
                r_acc <= '0;
            end
        end
    end

endmodule

// File: rtl/pll_frac_n.sv
// Digital fractional-N clock synthesiser. clk_out averages INT + FRAC/DEN
// clk_in cycles per period; new settings are taken over a valid/ready
// handshake and only switched in on period boundaries.
//
// state | meaning
// IDLE  | clk_out held low, pending config applied immediately
// RUN   | periods generated back to back
// STOP  | enable dropped, finishing the current period before IDLE
module pll_frac_n
    import pll_pkg::*;
#(
    parameter int INT_W        = 8,
    parameter int FRAC_W       = 12,
    parameter int LOCK_PERIODS = 4
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [INT_W-1:0]  cfg_int,
    input  logic [FRAC_W-1:0] cfg_frac,
    input  logic [FRAC_W-1:0] cfg_den,
    output logic              clk_out,
    output logic              period_start,
    output logic              locked
);

    localparam int CNT_W = INT_W + 1;
    localparam int LCK_W = $clog2(LOCK_PERIODS + 1);

    pll_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_p;
    logic [INT_W-1:0]  r_int;
    logic              r_clk_out;
    logic              r_period_start;
    logic [LCK_W-1:0]  r_lock_cnt;
    logic              r_locked;

    logic              r_pend_vld;
    logic [INT_W-1:0]  r_pend_int;
    logic [FRAC_W-1:0] r_pend_frac;
    logic [FRAC_W-1:0] r_pend_den;

    logic [FRAC_W-1:0] w_den_san;
    logic [FRAC_W-1:0] w_frac_san;
    logic [INT_W-1:0]  w_int_san;
    logic              w_boundary;
    logic              w_start;
    logic              w_apply;
    logic              w_carry;
    logic [INT_W-1:0]  w_int_eff;
    logic [CNT_W-1:0]  w_p_new;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [CNT_W-1:0]  w_half;
    logic [LCK_W-1:0]  w_lock_inc;

    // Order matters: den is fixed first so the frac clamp sees a nonzero den.
    assign w_den_san  = (cfg_den == '0) ? FRAC_W'(1) : cfg_den;
    assign w_int_san  = (cfg_int < INT_W'(MIN_INT)) ? INT_W'(MIN_INT) : cfg_int;
    assign w_frac_san = (cfg_frac >= w_den_san) ? (w_den_san - FRAC_W'(1)) : cfg_frac;

    assign w_boundary = (r_state != IDLE) && (r_cnt == (r_p - CNT_W'(1)));
    assign w_start    = enable && ((r_state == IDLE) || w_boundary);
    assign w_apply    = r_pend_vld && ((r_state == IDLE) || w_start);
    assign w_int_eff  = w_apply ? r_pend_int : r_int;
    assign w_p_new    = {1'b0, w_int_eff} + CNT_W'(w_carry);
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_half     = r_p >> 1;
    assign w_lock_inc = (r_lock_cnt == LCK_W'(LOCK_PERIODS)) ? r_lock_cnt
                                                             : (r_lock_cnt + LCK_W'(1));

    assign cfg_ready    = ~r_pend_vld;
    assign clk_out      = r_clk_out;
    assign period_start = r_period_start;
    assign locked       = r_locked;

    pll_frac_acc #(
        .FRAC_W (FRAC_W)
    ) u_acc (
        .clk_in  (clk_in),
        .rst     (rst),
        .i_step  (w_start),
        .i_load  (w_apply),
        .i_frac  (r_pend_frac),
        .i_den   (r_pend_den),
        .o_carry (w_carry)
    );

    // Pending config slot: capture sanitised values, release when applied.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_pend_vld  <= 1'b0;
            r_pend_int  <= INT_W'(RST_INT);
            r_pend_frac <= FRAC_W'(RST_FRAC);
            r_pend_den  <= FRAC_W'(RST_DEN);
        end else if (w_apply) begin
            r_pend_vld <= 1'b0;
        end else if (cfg_valid && !r_pend_vld) begin
            r_pend_vld  <= 1'b1;
            r_pend_int  <= w_int_san;
            r_pend_frac <= w_frac_san;
            r_pend_den  <= w_den_san;
        end
    end

    // Sequencer, period counter, lock tracking and registered outputs.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_p            <= CNT_W'(RST_INT);
            r_int          <= INT_W'(RST_INT);
            r_clk_out      <= 1'b0;
            r_period_start <= 1'b0;
            r_lock_cnt     <= '0;
            r_locked       <= 1'b0;
        end else begin
            r_period_start <= w_start;
            if (w_apply) begin
                r_int <= r_pend_int;
            end
            case (r_state)
                IDLE: begin
                    r_lock_cnt <= '0;
                    r_locked   <= 1'b0;
                    r_cnt      <= '0;
                    r_clk_out  <= 1'b0;
                    if (w_start) begin
                        r_state   <= RUN;
                        r_p       <= w_p_new;
                        r_clk_out <= 1'b1;
                    end
                end
                RUN, STOP: begin
                    if (w_boundary) begin
                        r_cnt <= '0;
                        if (w_start) begin
                            r_state   <= RUN;
                            r_p       <= w_p_new;
                            r_clk_out <= 1'b1;
                            if (w_apply) begin
                                r_lock_cnt <= '0;
                                r_locked   <= 1'b0;
                            end else begin
                                r_lock_cnt <= w_lock_inc;
                                r_locked   <= (w_lock_inc == LCK_W'(LOCK_PERIODS));
                            end
                        end else begin
                            r_state    <= IDLE;
                            r_clk_out  <= 1'b0;
                            r_lock_cnt <= '0;
                            r_locked   <= 1'b0;
                        end
                    end else begin
                        r_state   <= enable ? RUN : STOP;
                        r_cnt     <= w_cnt_inc;
                        r_clk_out <= (w_cnt_inc < w_half);
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_cnt      <= '0;
                    r_clk_out  <= 1'b0;
                    r_lock_cnt <= '0;
                    r_locked   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_frac_n.sv
// Directed bench for pll_frac_n: default ratio, integer and fractional
// reconfiguration, mid-period config, stop/re-enable, sanitising and reset.
module tb_pll_frac_n;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        enable;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_int;
    logic [11:0] cfg_frac;
    logic [11:0] cfg_den;
    logic        clk_out;
    logic        period_start;
    logic        locked;

    int total = 0;
    int bad   = 0;

    pll_frac_n #(
        .INT_W        (8),
        .FRAC_W       (12),
        .LOCK_PERIODS (4)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .enable       (enable),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_int      (cfg_int),
        .cfg_frac     (cfg_frac),
        .cfg_den      (cfg_den),
        .clk_out      (clk_out),
        .period_start (period_start),
        .locked       (locked)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [7:0] i, input logic [11:0] f, input logic [11:0] d);
        cfg_int   = i;
        cfg_frac  = f;
        cfg_den   = d;
        cfg_valid = 1'b1;
    endtask

    // Called just after a period-start edge: counts cycles and high cycles
    // until the next period_start, with a cycle bound.
    task automatic measure(output int n, output int h);
        n = 0;
        h = 0;
        do begin
            if (clk_out) h++;
            n++;
            step();
            cfg_valid = 1'b0;
        end while (!period_start && n < 20);
    endtask

    initial begin
        int n, h, tot;
        int exp_p[4];
        exp_p = '{4, 4, 4, 5};

        rst       = 1'b0;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_int   = '0;
        cfg_frac  = '0;
        cfg_den   = '0;

        #12;
        chk1("rst_clk_out", clk_out, 1'b0);
        chk1("rst_period_start", period_start, 1'b0);
        chk1("rst_locked", locked, 1'b0);
        chk1("rst_cfg_ready", cfg_ready, 1'b1);
        rst = 1'b1;
        step();
        chk1("idle_clk_out", clk_out, 1'b0);

        // Default ratio 2: 1 high / 1 low, lock on the 4th completed period.
        enable = 1'b1;
        step();
        chk1("start_clk", clk_out, 1'b1);
        chk1("start_ps", period_start, 1'b1);
        step();
        chk1("def_low_clk", clk_out, 1'b0);
        chk1("def_low_ps", period_start, 1'b0);
        repeat (6) step();
        chk1("def_unlocked_e7", locked, 1'b0);
        step();
        chk1("def_locked_e8", locked, 1'b1);
        chk1("def_e8_clk", clk_out, 1'b1);

        // Integer ratio 4.
        offer(8'd4, 12'd0, 12'd1);
        step();
        cfg_valid = 1'b0;
        chk1("int4_ready_low", cfg_ready, 1'b0);
        step();
        chk1("int4_ready_back", cfg_ready, 1'b1);
        chk1("int4_ps", period_start, 1'b1);
        chk1("int4_unlock", locked, 1'b0);
        measure(n, h);
        chkn("int4_len", n, 4);
        chkn("int4_high", h, 2);

        // Fractional 4 + 1/4: lengths 4,4,4,5 summing to 17.
        offer(8'd4, 12'd1, 12'd4);
        step();
        cfg_valid = 1'b0;
        chk1("frac_ready_low", cfg_ready, 1'b0);
        repeat (3) step();
        chk1("frac_apply_ps", period_start, 1'b1);
        chk1("frac_ready_back", cfg_ready, 1'b1);
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            measure(n, h);
            chkn("frac_len", n, exp_p[i]);
            chkn("frac_high", h, 2);
            tot += n;
            if (i == 2) chk1("frac_unlocked_3", locked, 1'b0);
        end
        chkn("frac_sum17", tot, 17);
        chk1("frac_locked_4", locked, 1'b1);

        // Back to integer 4, then 4 -> 6 accepted at cnt=1.
        offer(8'd4, 12'd0, 12'd1);
        measure(n, h);
        chkn("back4_cur_len", n, 4);
        offer(8'd6, 12'd0, 12'd1);
        measure(n, h);
        chkn("mid_cur_len", n, 4);
        chkn("mid_cur_high", h, 2);
        chk1("mid_ready_back", cfg_ready, 1'b1);
        chk1("mid_unlock", locked, 1'b0);
        for (int i = 0; i < 4; i++) begin
            measure(n, h);
            chkn("int6_len", n, 6);
            chkn("int6_high", h, 3);
            if (i == 2) chk1("int6_unlocked_3", locked, 1'b0);
        end
        chk1("int6_locked_4", locked, 1'b1);

        // Drop enable at cnt=1 of a P=6 period: 3 high / 3 low, then idle.
        step();
        enable = 1'b0;
        step();
        chk1("stop_hi", clk_out, 1'b1);
        step();
        chk1("stop_lo", clk_out, 1'b0);
        repeat (2) step();
        chk1("stop_lo_end", clk_out, 1'b0);
        chk1("stop_still_locked", locked, 1'b1);
        step();
        chk1("stop_idle_clk", clk_out, 1'b0);
        chk1("stop_idle_ps", period_start, 1'b0);
        chk1("stop_idle_unlock", locked, 1'b0);
        step();
        chk1("idle_hold", clk_out, 1'b0);

        // Restart, drop enable, re-enable during STOP: no gap.
        enable = 1'b1;
        step();
        chk1("re_start_ps", period_start, 1'b1);
        chk1("re_start_clk", clk_out, 1'b1);
        step();
        enable = 1'b0;
        step();
        enable = 1'b1;
        chk1("re_stop_hi", clk_out, 1'b1);
        step();
        chk1("re_run_lo", clk_out, 1'b0);
        repeat (2) step();
        chk1("re_no_early_ps", period_start, 1'b0);
        step();
        chk1("re_next_ps", period_start, 1'b1);
        chk1("re_next_clk", clk_out, 1'b1);

        // int=1, frac=5, den=0 must become 2 + 0/1.
        offer(8'd1, 12'd5, 12'd0);
        measure(n, h);
        chkn("san_cur_len", n, 6);
        measure(n, h);
        chkn("san_len_a", n, 2);
        chkn("san_high_a", h, 1);
        measure(n, h);
        chkn("san_len_b", n, 2);

        // Asynchronous reset during a high phase.
        chk1("pre_rst_hi", clk_out, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk1("async_rst_clk", clk_out, 1'b0);
        chk1("async_rst_ps", period_start, 1'b0);
        chk1("async_rst_lock", locked, 1'b0);
        chk1("async_rst_ready", cfg_ready, 1'b1);
        enable = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk1("post_rst_idle", clk_out, 1'b0);
        enable = 1'b1;
        step();
        chk1("post_rst_ps", period_start, 1'b1);
        measure(n, h);
        chkn("post_rst_len", n, 2);
        chkn("post_rst_high", h, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_frac_n.md
# pll_frac_n

Parametrised digital fractional-N clock synthesiser, successor to the integer-N PLL.
- Derives `clk_out` from `clk_in` with an average period of `INT + FRAC/DEN` input cycles, using a first-order accumulator that selects N or N+1 per period.
- Accepts runtime reconfiguration over a valid/ready handshake and applies it only on output-period boundaries.
- Starts and stops `clk_out` glitch-free and reports lock.
- Sits between the reference clock input and downstream clock consumers/test logic.

## Interface
- `INT_W`, default 8: width of the integer divide ratio.
- `FRAC_W`, default 12: width of the fractional numerator and denominator.
- `LOCK_PERIODS`, default 4: completed output periods with unchanged config required before `locked` asserts.
- `clk_in`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request, sampled on `clk_in`.
- `cfg_valid`  in  1  new configuration offered.
- `cfg_ready`  out  1  no pending configuration; config can be accepted.
- `cfg_int`  in  INT_W  integer divide ratio.
- `cfg_frac`  in  FRAC_W  fractional numerator.
- `cfg_den`  in  FRAC_W  fractional denominator.
- `clk_out`  out  1  synthesised clock (registered).
- `period_start`  out  1  one-cycle pulse on the first input cycle of each output period.
- `locked`  out  1  output period sequence is stable.

## Operation
- Reset values:
  - Outputs: `clk_out`=0, `period_start`=0, `locked`=0, `cfg_ready`=1.
  - Active config: int=2, frac=0, den=1.
  - Internal: acc=0, cnt=0, lock count=0, pending empty, state IDLE.
- Config handshake:
  - A transfer occurs when `cfg_valid` and `cfg_ready` are both 1 on an edge; the values are captured into the pending register.
  - `cfg_ready` is 0 from the next cycle until the pending config is applied.
- Sanitising at capture, applied in this order:
  - den==0 becomes 1.
  - int<2 becomes 2.
  - frac>=den becomes den-1.
- Applying pending config:
  - Happens at the start of the next period, or immediately in IDLE.
  - Applying resets acc to 0, clears the lock count, drops `locked`, and re-raises `cfg_ready`.
- Period length P is decided at each period start:
  - sum = acc + frac, computed FRAC_W+1 bits wide.
  - If sum >= den: carry=1 and acc = sum - den. Otherwise carry=0 and acc = sum.
  - P = int + carry, computed INT_W+1 bits wide.
- Within a period, cnt runs from 0 to P-1.
  - `clk_out` is 1 while cnt < P>>1, else 0. Example: P=2 gives 1 high, 1 low; P=5 gives 2 high, 3 low.
- FSM states: IDLE, RUN, STOP.
  - IDLE: `clk_out`=0. On `enable`=1 go to RUN, starting a period on that same edge.
  - RUN: at end of period with `enable`=1, start the next period. On `enable`=0 go to STOP.
  - STOP: finish the current period. At its end go to IDLE with `clk_out`=0. If `enable` returns to 1 before the period ends, go back to RUN with no gap or truncation.
- `locked`:
  - The lock count increments on each period completed in RUN or STOP; it saturates at LOCK_PERIODS.
  - `locked` is 1 while count == LOCK_PERIODS.
  - Entering IDLE clears both the count and `locked`.
- Simultaneous events:
  - Config accepted on the period-boundary edge is not applied until the following boundary.
  - `enable` falling on a boundary edge starts no new period; the FSM goes directly to IDLE.

## Timing
- Start latency: `clk_out` and `period_start` are 1 after the first edge that samples `enable`=1 in IDLE.
- Apply latency: the new ratio is in effect on the first period starting at least 1 edge after acceptance.
- `period_start` coincides with the rising edge of `clk_out` (P>=2 always).
- Stop: `clk_out` is 0 within P-1 edges of sampling `enable`=0; the final high phase is never truncated.
- Reset asserted mid-operation: all outputs go to reset values immediately, asynchronously. Outputs resume only after deassertion and a sampled `enable`.
- Averaging: over DEN consecutive periods the total is exactly INT*DEN+FRAC input cycles.

## Structure
- Package `pll_pkg` holds:
  - state enum {IDLE, RUN, STOP}.
  - Reset-default constants (INT=2, FRAC=0, DEN=1).
  - MIN_INT=2.
- Sub-module `pll_frac_acc`: holds acc and the frac/den registers. It takes a step strobe and a load strobe and returns carry.
- The top level holds the FSM, cnt, pending-config handshake, lock counter and output registers.

## Test plan
- Reset, then `enable`=1 with default config: `clk_out` toggles 1/1. `locked`=1 after the 4th period completes, at edge 8.
- cfg int=4, frac=0, den=1: every period is 4 cycles, high 2 / low 2. `cfg_ready` is 0 for at most one period.
- cfg int=4, frac=1, den=4: period lengths repeat 4,4,4,5. 17 cycles per 4 periods; `period_start` spacing matches.
- Config accepted mid-period (int 4 to 6, at cnt=1): current period finishes at 4, next is 6. `locked` drops and re-asserts after 4 more periods.
- `enable` dropped at cnt=1 of a P=6 period: `clk_out` completes 3 high / 3 low, then stays 0. Re-enable during STOP: next period follows with no gap.
- cfg int=1, den=0, frac=5 maps to int=2, den=1, frac=0. `rst` pulsed low mid-high-phase: `clk_out` goes to 0 immediately.
